// File: rtl/signal_frame_serializer.sv
// Frame-to-pixel-stream serializer: captures flattened frames and emits one pixel per
// valid/ready beat with start/end markers, holding up to one pending frame behind the active one.
module signal_frame_serializer #(
  parameter int WIDTH_PIXELS      = 2,
  parameter int HEIGHT_PIXELS     = 2,
  parameter int PIXEL_SIZE_BITS   = 8,
  parameter int DEFAULT_INTENSITY = 0
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [WIDTH_PIXELS*HEIGHT_PIXELS*PIXEL_SIZE_BITS-1:0] frame_in,
  input  logic                                                  frame_valid,
  output logic                                                  frame_ready,
  output logic [PIXEL_SIZE_BITS-1:0]                            m_tdata,
  output logic                                                  m_tvalid,
  input  logic                                                  m_tready,
  output logic                                                  m_tuser,
  output logic                                                  m_tlast,
  output logic                                                  frame_dropped,
  output logic [15:0]                                           frame_count
);

  localparam int N  = WIDTH_PIXELS * HEIGHT_PIXELS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PIXEL_SIZE_BITS-1:0] DEF_PIX = PIXEL_SIZE_BITS'(DEFAULT_INTENSITY);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [PIXEL_SIZE_BITS-1:0] r_buf_a [N];
  logic [PIXEL_SIZE_BITS-1:0] r_buf_p [N];
  logic [PIXEL_SIZE_BITS-1:0] w_frame_pix [N];
  logic                       r_pend_valid;
  logic [IW-1:0]              r_idx;
  logic [15:0]                r_frame_count;
  logic                       r_dropped;

  logic w_frame_ready;
  logic w_accept;
  logic w_drop;
  logic w_beat;
  logic w_idx_last;
  logic w_last_beat;
  logic w_load_a_in;
  logic w_load_a_p;
  logic w_load_p;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_frame_pix[i] = frame_in[i*PIXEL_SIZE_BITS +: PIXEL_SIZE_BITS];
    end
  end

  // Handshake decode; ready depends only on registered state so it never loops through m_tready.
  always_comb begin
    w_frame_ready = (r_state == S_IDLE) || !r_pend_valid;
    w_accept      = frame_valid && w_frame_ready;
    w_drop        = frame_valid && !w_frame_ready;
    w_beat        = (r_state == S_STREAM) && m_tready;
    w_idx_last    = (r_idx == IW'(N - 1));
    w_last_beat   = w_beat && w_idx_last;
    // A last beat with nothing pending lets a same-cycle frame go straight into A.
    w_load_a_in   = w_accept && ((r_state == S_IDLE) || (w_last_beat && !r_pend_valid));
    w_load_a_p    = w_last_beat && r_pend_valid;
    w_load_p      = w_accept && (r_state == S_STREAM) && !w_last_beat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    m_tvalid    = 1'b0;
    m_tdata     = DEF_PIX;
    m_tuser     = 1'b0;
    m_tlast     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        m_tvalid = 1'b1;
        m_tdata  = r_buf_a[r_idx];
        m_tuser  = (r_idx == '0);
        m_tlast  = w_idx_last;
        if (w_last_beat && !r_pend_valid && !w_accept) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx         <= '0;
      r_pend_valid  <= 1'b0;
      r_frame_count <= '0;
      r_dropped     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_buf_a[i] <= DEF_PIX;
        r_buf_p[i] <= DEF_PIX;
      end
    end else begin
      r_dropped <= w_drop;
      if (w_load_a_in) begin
        r_buf_a <= w_frame_pix;
      end else if (w_load_a_p) begin
        r_buf_a <= r_buf_p;
      end
      if (w_load_p) begin
        r_buf_p <= w_frame_pix;
      end
      if (w_load_a_p) begin
        r_pend_valid <= 1'b0;
      end else if (w_load_p) begin
        r_pend_valid <= 1'b1;
      end
      if (r_state == S_IDLE) begin
        r_idx <= '0;
      end else if (w_beat) begin
        r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
      end
      if (w_last_beat) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign frame_ready   = w_frame_ready;
  assign frame_dropped = r_dropped;
  assign frame_count   = r_frame_count;

endmodule
